// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions and the decode-to-execute
// bundle layout for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_FWD_BUS_WD   = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // first member is the MSB, matching the decode-side layout
  typedef struct packed {
    logic [11:0] alu_op;       // [135:124]
    logic        res_from_mem; // [123]
    logic        src1_is_sa;   // [122]
    logic        src1_is_pc;   // [121]
    logic        src2_is_imm;  // [120]
    logic        src2_is_8;    // [119]
    logic        gr_we;        // [118]
    logic        mem_we;       // [117]
    logic [4:0]  dest;         // [116:112]
    logic [15:0] imm;          // [111:96]
    logic [31:0] rs_value;     // [95:64]
    logic [31:0] rt_value;     // [63:32]
    logic [31:0] pc;           // [31:0]
  } ds_to_es_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational one-hot ALU for the execute stage.
// An all-zero opcode yields zero.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [4:0] sa;
  assign sa = src1[4:0];

  always_comb begin
    result = '0;
    unique case (1'b1)
      alu_op[ALU_ADD]:  result = src1 + src2;
      alu_op[ALU_SUB]:  result = src1 - src2;
      alu_op[ALU_SLT]:  result = {31'b0, $signed(src1) < $signed(src2)};
      alu_op[ALU_SLTU]: result = {31'b0, src1 < src2};
      alu_op[ALU_AND]:  result = src1 & src2;
      alu_op[ALU_NOR]:  result = ~(src1 | src2);
      alu_op[ALU_OR]:   result = src1 | src2;
      alu_op[ALU_XOR]:  result = src1 ^ src2;
      alu_op[ALU_SLL]:  result = src2 << sa;
      alu_op[ALU_SRL]:  result = src2 >> sa;
      alu_op[ALU_SRA]:  result = $unsigned($signed(src2) >>> sa);
      alu_op[ALU_LUI]:  result = {src2[15:0], 16'b0};
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline register, operand muxes, ALU, data-SRAM
// request and result/forwarding bus packing.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic      es_valid_q, es_valid_d;
  ds_to_es_t es_bus_q, es_bus_d;
  logic      es_ready_go;
  logic      fire;
  logic [31:0] src1, src2, alu_result;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_to_es_valid && es_allowin) es_bus_d = ds_to_es_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) es_valid_q <= 1'b0;
    else       es_valid_q <= es_valid_d;
  end

  always_ff @(posedge clk) begin
    es_bus_q <= es_bus_d;
  end

  always_comb begin
    src1 = es_bus_q.rs_value;
    if (es_bus_q.src1_is_sa)      src1 = {27'b0, es_bus_q.imm[10:6]};
    else if (es_bus_q.src1_is_pc) src1 = es_bus_q.pc;
    src2 = es_bus_q.rt_value;
    if (es_bus_q.src2_is_imm)    src2 = {{16{es_bus_q.imm[15]}}, es_bus_q.imm};
    else if (es_bus_q.src2_is_8) src2 = 32'd8;
  end

  alu u_alu (
    .alu_op (es_bus_q.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (alu_result)
  );

  // a request in the reset cycle would be a write the core never retires
  assign fire = es_valid_q && es_ready_go && ms_allowin && !reset;

  assign data_sram_en    = fire && (es_bus_q.res_from_mem || es_bus_q.mem_we);
  assign data_sram_wen   = {4{fire && es_bus_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_bus_q.rt_value;

  assign es_to_ms_bus = {es_bus_q.res_from_mem, es_bus_q.gr_we,
                         es_bus_q.dest, alu_result, es_bus_q.pc};

  assign es_fwd_bus = {es_valid_q && es_bus_q.gr_we && (es_bus_q.dest != 5'd0),
                       es_valid_q && es_bus_q.res_from_mem,
                       es_bus_q.dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed cases plus randomized
// traffic checked against a behavioural reference model.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_allowin;
  logic        es_allowin;
  logic        ds_to_es_valid;
  ds_to_es_t   ds_to_es_bus;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic [38:0] es_fwd_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_fwd_bus      (es_fwd_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [70:0] ms_bus;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [38:0] fwd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;

  task automatic chk(string name, logic [70:0] act, logic [70:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(ds_to_es_t b);
    logic [31:0] a, c;
    logic [63:0] ext;
    int s, k;
    a = b.src1_is_sa ? {27'b0, b.imm[10:6]} : b.src1_is_pc ? b.pc : b.rs_value;
    c = b.src2_is_imm ? {{16{b.imm[15]}}, b.imm} : b.src2_is_8 ? 32'd8 : b.rt_value;
    s = int'(a[4:0]);
    k = -1;
    for (int i = 0; i < 12; i++) if (b.alu_op[i]) k = i;
    ext = {{32{c[31]}}, c} >> s;
    case (k)
      0:  return a + c;
      1:  return a - c;
      2:  return (int'(a) < int'(c)) ? 32'd1 : 32'd0;
      3:  return (longint'(a) < longint'(c)) ? 32'd1 : 32'd0;
      4:  return a & c;
      5:  return ~(a | c);
      6:  return a | c;
      7:  return a ^ c;
      8:  return c << s;
      9:  return c >> s;
      10: return ext[31:0];
      11: return c * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(ds_to_es_t b);
    exp_t e;
    logic [31:0] r;
    r = ref_alu(b);
    e.ms_bus = {b.res_from_mem, b.gr_we, b.dest, r, b.pc};
    e.en     = b.res_from_mem | b.mem_we;
    e.wen    = b.mem_we ? 4'hF : 4'h0;
    e.addr   = r;
    e.wdata  = b.rt_value;
    e.fwd    = {b.gr_we && (b.dest != 0), b.res_from_mem, b.dest, r};
    return e;
  endfunction

  // issue side: record every accepted instruction
  always @(posedge clk) begin
    if (reset) q.delete();
    else if (ds_to_es_valid && es_allowin) q.push_back(model(ds_to_es_bus));
  end

  // monitor: compare stage outputs against the head of the queue
  always @(negedge clk) begin
    if (data_sram_en && (data_sram_wen != 0)) writes++;
    if (reset) begin
      chk("rst_sram_en", 71'(data_sram_en), 71'(0));
    end else begin
      chk("allowin", 71'(es_allowin), 71'((q.size() == 0) || ms_allowin));
      if (q.size() == 0) begin
        chk("idle_valid", 71'(es_to_ms_valid), 71'(0));
        chk("idle_fwd", 71'(es_fwd_bus[38:37]), 71'(0));
        chk("idle_en", 71'({data_sram_en, data_sram_wen}), 71'(0));
      end else begin
        chk("valid", 71'(es_to_ms_valid), 71'(1));
        chk("fwd", 71'(es_fwd_bus), 71'(q[0].fwd));
        if (ms_allowin) begin
          chk("ms_bus", es_to_ms_bus, q[0].ms_bus);
          chk("sram_en", 71'({data_sram_en, data_sram_wen}),
              71'({q[0].en, q[0].wen}));
          if (q[0].en) begin
            chk("sram_addr", 71'(data_sram_addr), 71'(q[0].addr));
            chk("sram_wdata", 71'(data_sram_wdata), 71'(q[0].wdata));
          end
          void'(q.pop_front());
        end else begin
          chk("stall_en", 71'({data_sram_en, data_sram_wen}), 71'(0));
        end
      end
    end
  end

  task automatic step(logic v, ds_to_es_t b, logic ma);
    @(posedge clk);
    #1;
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = ma;
  endtask

  function automatic ds_to_es_t mk(int op, logic [4:0] dest, logic [15:0] imm,
                                   logic [31:0] rs, logic [31:0] rt,
                                   logic [31:0] pc, logic [6:0] fl);
    ds_to_es_t b;
    b = '0;
    b.alu_op = (op < 0) ? 12'd0 : (12'd1 << op);
    {b.res_from_mem, b.src1_is_sa, b.src1_is_pc, b.src2_is_imm,
     b.src2_is_8, b.gr_we, b.mem_we} = fl;
    b.dest = dest; b.imm = imm; b.rs_value = rs;
    b.rt_value = rt; b.pc = pc;
    return b;
  endfunction

  // run a single instruction through and check its result
  task automatic run1(string name, ds_to_es_t b, logic [31:0] exp_res);
    step(1'b1, b, 1'b1);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    chk({name, "_res"}, 71'(es_to_ms_bus[63:32]), 71'(exp_res));
    chk({name, "_vld"}, 71'(es_to_ms_valid), 71'(1));
  endtask

  localparam logic [6:0] F_GR  = 7'b0000010;
  localparam logic [6:0] F_SA  = 7'b0100010;
  localparam logic [6:0] F_JAL = 7'b0010110;
  localparam logic [6:0] F_IMM = 7'b0001010;
  localparam logic [6:0] F_SW  = 7'b0001001;
  localparam logic [6:0] F_LW  = 7'b1001010;

  ds_to_es_t b;
  int        w0;

  initial begin
    reset = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    ms_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 71'(es_allowin), 71'(1));
    chk("rst_valid", 71'(es_to_ms_valid), 71'(0));
    chk("rst_fwd", 71'(es_fwd_bus[38:37]), 71'(0));

    b = mk(ALU_ADD, 5'd3, 16'h0, 32'hFFFF_FFFF, 32'd2, 32'h0, F_GR);
    run1("addu", b, 32'h1);
    chk("addu_en", 71'(data_sram_en), 71'(0));
    run1("slt", mk(ALU_SLT, 5'd4, 16'h0, 32'h8000_0000, 32'd1, 32'h0, F_GR), 32'd1);
    run1("sltu", mk(ALU_SLTU, 5'd4, 16'h0, 32'h8000_0000, 32'd1, 32'h0, F_GR), 32'd0);
    run1("sra", mk(ALU_SRA, 5'd6, 16'h0100, 32'h0, 32'h8000_0000, 32'h0, F_SA),
         32'hF800_0000);
    run1("jal", mk(ALU_ADD, 5'd31, 16'h0, 32'h0, 32'h0, 32'hBFC0_0010, F_JAL),
         32'hBFC0_0018);
    chk("jal_dest", 71'(es_to_ms_bus[68:64]), 71'(31));
    run1("lui", mk(ALU_LUI, 5'd7, 16'h8001, 32'h0, 32'h0, 32'h0, F_IMM),
         32'h8001_0000);

    // store held by the memory stage for three cycles
    b = mk(ALU_ADD, 5'd0, 16'hFFFC, 32'h100, 32'hDEAD_BEEF, 32'h0, F_SW);
    w0 = writes;
    step(1'b1, b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      @(negedge clk);
      chk("sw_stall_allowin", 71'(es_allowin), 71'(0));
      chk("sw_stall_en", 71'(data_sram_en), 71'(0));
    end
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("sw_en", 71'({data_sram_en, data_sram_wen}), 71'(5'h1F));
    chk("sw_addr", 71'(data_sram_addr), 71'(32'hFC));
    chk("sw_wdata", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("sw_once", 71'(writes - w0), 71'(1));

    // load forwarding and dest=0 suppression
    step(1'b1, mk(ALU_ADD, 5'd5, 16'h4, 32'h200, 32'h0, 32'h0, F_LW), 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("lw_fwd", 71'(es_fwd_bus[38:32]), 71'({2'b11, 5'd5}));
    step(1'b0, '0, 1'b1);
    run1("add_r0", mk(ALU_ADD, 5'd0, 16'h0, 32'd1, 32'd1, 32'h0, F_GR), 32'd2);
    chk("r0_fwd_we", 71'(es_fwd_bus[38]), 71'(0));

    // reset while a store is stalled
    w0 = writes;
    step(1'b1, b, 1'b0);
    step(1'b0, '0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("rst_sw_valid", 71'(es_to_ms_valid), 71'(0));
    chk("rst_sw_allowin", 71'(es_allowin), 71'(1));
    repeat (3) @(negedge clk);
    chk("rst_sw_nowrite", 71'(writes - w0), 71'(0));

    // randomized traffic with random back-pressure and bubbles
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 12);
      b = mk((r == 12) ? -1 : r, 5'($urandom), 16'($urandom), $urandom,
             $urandom, $urandom, 7'($urandom));
      step(($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 7));
    end
    step(1'b0, '0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain", 71'(q.size()), 71'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
